inst_prefetch_queue: RTL
========================

Name: inst_prefetch_queue

Overview:
- Sits between the core instruction port (`inst_ren` / `inst_addr` / `inst_data`) and a slower multi-cycle instruction memory that uses a req/ack handshake.
- Prefetches sequential words into a DEPTH-entry queue and serves the core in zero cycles on a hit.
- Raises `inst_stall` on a miss and redirects (flushes and refetches) when the core changes flow (branch or jump).

Parameters:
DEPTH  4  queue entries; power of two, >= 2
RESET_PC  32'h0000_0000  first fetch address after reset

Ports:
clk  input  1  main clock, rising edge
rst  input  1  asynchronous reset, active-low
inst_ren  input  1  core instruction read request
inst_addr  input  32  core instruction address; bits [1:0] ignored
inst_data  output  32  instruction returned to core; valid when inst_ren=1 and inst_stall=0
inst_stall  output  1  requested word not available this cycle; core holds inst_addr
ext_req  output  1  request to instruction memory
ext_addr  output  32  word-aligned fetch address; stable while ext_req=1
ext_ack  input  1  memory returns ext_data this cycle; ends request
ext_data  input  32  fetched word, sampled when ext_ack=1

Behaviour:
- Reset (rst=0, asynchronous):
  - Queue empty, count=0.
  - fetch_addr=RESET_PC, state=IDLE.
  - ext_req=0, ext_addr=RESET_PC.
  - inst_data=0, inst_stall=0.
- Queue entry: {addr[31:2], data[31:0]}. Head pointer, tail pointer and count use wrap-around at DEPTH.
- hit (combinational): inst_ren=1 AND count>0 AND inst_addr[31:2]==head.addr.
  - inst_data=head.data, inst_stall=0.
  - Head pops at the clock edge.
- bypass (combinational): inst_ren=1 AND count==0 AND state==REQ AND ext_ack=1 AND ext_addr[31:2]==inst_addr[31:2].
  - inst_data=ext_data, inst_stall=0.
  - The word is not pushed; fetch_addr+=4.
- Otherwise: inst_data=0, and inst_stall = inst_ren AND NOT (hit OR bypass).
- inst_ren=0: inst_stall=0, no pop; prefetch continues.
- Redirect condition: inst_ren=1, no hit, no bypass, and one of the following:
  - count>0 (head address mismatch), or
  - count==0 and the in-flight or next fetch address != inst_addr.
- Redirect action: flush queue (count=0, head=tail), fetch_addr = {inst_addr[31:2],2'b00}.
  - If state==REQ and no ack this cycle, go to DROP.
- Fetch FSM (at most one outstanding request):
  - IDLE:
    - If (count - pop + push) < DEPTH and no redirect: ext_req=1, ext_addr=fetch_addr, go to REQ next cycle.
    - If count==DEPTH: no request.
  - REQ:
    - ext_req and ext_addr held stable until ext_ack.
    - On ack: push {ext_addr, ext_data} (unless bypassed or redirected), fetch_addr+=4, go to IDLE.
    - Redirect in the same cycle as ack: data discarded, go to IDLE with the new fetch_addr.
  - DROP:
    - ext_req held with the old ext_addr (the handshake may not be withdrawn).
    - On ack: data discarded, go to IDLE.
    - Further redirects while in DROP only update fetch_addr.
- A request may be issued in the cycle after an ack (IDLE lasts 1 cycle minimum). Steady-state throughput is one word per (memory latency + 1) cycles.
- Push and pop in the same cycle: count unchanged, and the full check uses the net value.
- fetch_addr wraps 32'hFFFF_FFFC -> 32'h0000_0000.
- Reset asserted mid-request: ext_req drops immediately. Memory must tolerate an abandoned request.
- ext_ack while ext_req=0: ignored.

Test Plan:
1. Reset with RESET_PC=0, mem latency 2, core reading 0,4,8 ->
   - ext_req addresses are 0,4,8,...
   - First word is bypassed on ack: inst_stall=1 for 2 cycles, then inst_data=mem[0].
   - Later words hit with inst_stall=0 once the queue is ahead.
2. inst_ren=0 for 20 cycles ->
   - Exactly DEPTH=4 words fetched (0..C); ext_req stays 0 while full.
   - Then reads of 0,4,8,C all hit with no stall, and fetching resumes at 0x10.
3. Queue holds 0x10..0x1C, core presents 0x40 ->
   - Flush; inst_stall=1; next ext_addr=0x40.
   - inst_data=mem[0x40] on its ack; 0x44 follows.
4. Redirect to 0x80 while a request to 0x24 is outstanding ->
   - ext_req stays high with ext_addr=0x24 until ack (DROP).
   - mem[0x24] is never returned to the core.
   - Next ext_addr=0x80.
5. Redirect in the same cycle as ext_ack for 0x24 -> data discarded, ext_addr=0x80 issued one cycle later.
6. RESET_PC=32'hFFFF_FFF8 ->
   - Fetch sequence FFFF_FFF8, FFFF_FFFC, 0000_0000.
   - Asserting rst mid-REQ drops ext_req asynchronously, and count reads 0.

Source files
------------

// File: rtl/inst_prefetch_queue.sv
// inst_prefetch_queue: sequential instruction prefetch queue between core fetch port and req/ack instruction memory
module inst_prefetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        inst_ren,
  input  logic [31:0] inst_addr,
  output logic [31:0] inst_data,
  output logic        inst_stall,
  output logic        ext_req,
  output logic [31:0] ext_addr,
  input  logic        ext_ack,
  input  logic [31:0] ext_data
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  localparam logic [1:0] IDLE = 2'd0, REQ = 2'd1, DROP = 2'd2;
  logic [29:0] qa_q [DEPTH];
  logic [31:0] qd_q [DEPTH];
  logic [AW-1:0] head_q, head_d, tail_q, tail_d;
  logic [AW:0] count_q, count_d, count_net;
  logic [31:0] fetch_addr_q, fetch_addr_d, ext_addr_q, ext_addr_d, next_addr;
  logic [1:0] state_q, state_d;
  logic ack_req, hit, bypass, redirect, push, unused_ok;
  assign unused_ok = ^inst_addr[1:0];
  assign ack_req = state_q == REQ && ext_ack;
  assign hit = inst_ren && count_q != '0 && inst_addr[31:2] == qa_q[head_q];
  assign bypass = inst_ren && count_q == '0 && ack_req && ext_addr_q[31:2] == inst_addr[31:2];
  // with an empty queue the core is only on-path if it wants the word in flight (REQ) or the next one to fetch
  assign next_addr = state_q == REQ ? ext_addr_q : fetch_addr_q;
  assign redirect = inst_ren && !hit && !bypass && (count_q != '0 || next_addr[31:2] != inst_addr[31:2]);
  assign push = ack_req && !bypass && !redirect;
  assign count_net = count_q - (AW+1)'(hit) + (AW+1)'(push);
  assign inst_data = hit ? qd_q[head_q] : bypass ? ext_data : '0;
  assign inst_stall = inst_ren && !hit && !bypass;
  assign ext_req = state_q != IDLE;
  assign ext_addr = ext_addr_q;
  always_comb begin
    count_d = redirect ? '0 : count_net;
    head_d = redirect ? tail_q : head_q + AW'(hit);
    tail_d = tail_q + AW'(push);
    fetch_addr_d = redirect ? {inst_addr[31:2], 2'b00} : ack_req ? fetch_addr_q + 32'd4 : fetch_addr_q;
    state_d = state_q == IDLE ? ((!redirect && count_net < FULL) ? REQ : IDLE)
            : state_q == REQ  ? (ext_ack ? IDLE : redirect ? DROP : REQ)
            : (ext_ack ? IDLE : DROP);
    ext_addr_d = (state_q == IDLE && state_d == REQ) ? fetch_addr_q : ext_addr_q;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_q <= '0;
      tail_q <= '0;
      count_q <= '0;
      fetch_addr_q <= RESET_PC;
      ext_addr_q <= RESET_PC;
      state_q <= IDLE;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      count_q <= count_d;
      fetch_addr_q <= fetch_addr_d;
      ext_addr_q <= ext_addr_d;
      state_q <= state_d;
    end
  end
  always_ff @(posedge clk) begin
    if (push) begin
      qa_q[tail_q] <= ext_addr_q[31:2];
      qd_q[tail_q] <= ext_data;
    end
  end
endmodule
